// File: rtl/game_pkg.sv
// Shared game definitions: obstacle word layout, obstacle types, game states,
// and the button bundle passed between the scheduler and its latch.
package game_pkg;

  typedef enum logic [2:0] {
    OBS_EMPTY  = 3'd0,
    OBS_LOW    = 3'd1,
    OBS_HIGH   = 3'd2,
    OBS_MIDDLE = 3'd3,
    OBS_TRAIN  = 3'd4,
    OBS_RAMP   = 3'd5,
    OBS_MOVING = 3'd6
  } obstacle_type_t;

  // Obstacle word field slices
  localparam int TYPE_MSB  = 15;
  localparam int TYPE_LSB  = 13;
  localparam int LANE_MSB  = 12;
  localparam int LANE_LSB  = 11;
  localparam int DEPTH_MSB = 10;
  localparam int DEPTH_LSB = 0;

  localparam int HALF_BLOCK_LENGTH = 160;

  typedef enum logic [1:0] {
    GS_TITLE = 2'd0,
    GS_RUN   = 2'd1,
    GS_OVER  = 2'd2
  } game_state_t;

  typedef struct packed {
    logic jump;
    logic duck;
    logic left;
    logic right;
  } btn_t;

  function automatic obstacle_type_t obs_type(input logic [15:0] w);
    return obstacle_type_t'(w[TYPE_MSB:TYPE_LSB]);
  endfunction

  function automatic logic [10:0] obs_depth(input logic [15:0] w);
    return w[DEPTH_MSB:DEPTH_LSB];
  endfunction

endpackage

// File: rtl/button_latch.sv
// Four sticky button latches that are released to game_logic on the frame tick.
module button_latch
  import game_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,     // accumulate only while the game is running
  input  logic clr,    // restart / leave RUN: drop anything pending
  input  logic tick,   // gl_new_frame cycle
  input  btn_t pulse,
  output btn_t fwd
);

  btn_t q;

  // Sticky set; the tick clears, but a pulse landing on the tick survives
  always_ff @(posedge clk) begin
    if (rst || clr) q <= '0;
    else            q <= btn_t'((tick ? 4'b0 : q) | (en ? pulse : 4'b0));
  end

  // Forward on the tick only; opposing left/right cancel, jump/duck both pass
  always_comb begin
    fwd = '0;
    if (tick) begin
      fwd.jump  = q.jump;
      fwd.duck  = q.duck;
      fwd.left  = q.left  & ~q.right;
      fwd.right = q.right & ~q.left;
    end
  end

endmodule

// File: rtl/frame_scheduler.sv
// Per-frame sequencer in front of game_logic: scans the obstacle slot memory,
// fires the frame tick with latched buttons, and runs the TITLE/RUN/OVER FSM.
module frame_scheduler
  import game_pkg::*;
#(
  parameter  int NUM_SLOTS       = 32,
  parameter  int FIRSTROW_DEPTH  = 320,
  parameter  int RESTART_HOLDOFF = 60,
  localparam int ADDR_W          = $clog2(NUM_SLOTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              btn_jump,
  input  logic              btn_duck,
  input  logic              btn_left,
  input  logic              btn_right,
  input  logic              game_over_in,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       obstacle,
  output logic              obstacle_valid,
  output logic              firstrow,
  output logic              gl_new_frame,
  output logic              gl_jump,
  output logic              gl_duck,
  output logic              gl_left,
  output logic              gl_right,
  output logic              gl_rst,
  output logic [1:0]        game_state,
  output logic              scan_busy,
  output logic              frame_overrun
);

  localparam int               HO_W      = $clog2(RESTART_HOLDOFF + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SLOTS - 1);
  localparam logic [10:0]       FR_DEPTH  = 11'(FIRSTROW_DEPTH);

  typedef enum logic [1:0] {SC_IDLE, SC_READ, SC_DRAIN, SC_TICK} scan_state_t;

  scan_state_t       sc_q, sc_d;
  game_state_t       gs_q, gs_d;
  logic [ADDR_W-1:0] addr_q;
  logic [HO_W-1:0]   holdoff_q, holdoff_d;
  logic              rst_pulse_q;
  logic              restart, go_over, scan_start, any_btn, tick;
  btn_t              btn_in, btn_fwd;

  assign btn_in  = '{jump: btn_jump, duck: btn_duck, left: btn_left, right: btn_right};
  assign any_btn = |btn_in;
  assign tick    = (sc_q == SC_TICK);

  // A frame_start on the restart cycle is dropped, and game over wins over a new scan
  assign scan_start = (gs_q == GS_RUN) && (sc_q == SC_IDLE) && frame_start &&
                      !rst_pulse_q && !game_over_in;

  // Scan and game state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sc_q        <= SC_IDLE;
      gs_q        <= GS_TITLE;
      holdoff_q   <= '0;
      rst_pulse_q <= 1'b0;
    end else begin
      sc_q        <= sc_d;
      gs_q        <= gs_d;
      holdoff_q   <= holdoff_d;
      rst_pulse_q <= restart;
    end
  end

  // Scan sequencing: 1 start cycle, NUM_SLOTS reads, 1 drain, 1 tick
  always_comb begin
    sc_d = sc_q;
    case (sc_q)
      SC_IDLE:  if (scan_start) sc_d = SC_READ;
      SC_READ:  if (addr_q == LAST_ADDR) sc_d = SC_DRAIN;
      SC_DRAIN: sc_d = SC_TICK;
      SC_TICK:  sc_d = SC_IDLE;
      default:  sc_d = SC_IDLE;
    endcase
  end

  // Game FSM; game_over_in is ignored on the restart cycle since game_logic
  // is still clearing its previous game over then
  always_comb begin
    gs_d      = gs_q;
    holdoff_d = holdoff_q;
    restart   = 1'b0;
    go_over   = 1'b0;
    case (gs_q)
      GS_TITLE: if (any_btn) begin
        restart = 1'b1;
        gs_d    = GS_RUN;
      end
      GS_RUN: if (sc_q == SC_IDLE && game_over_in && !rst_pulse_q) begin
        go_over   = 1'b1;
        gs_d      = GS_OVER;
        holdoff_d = HO_W'(RESTART_HOLDOFF);
      end
      GS_OVER: begin
        if (any_btn && holdoff_q == '0) begin
          restart = 1'b1;
          gs_d    = GS_RUN;
        end else if (frame_start && holdoff_q != '0) begin
          holdoff_d = holdoff_q - 1'b1;
        end
      end
      default: gs_d = GS_TITLE;
    endcase
  end

  // Read address walks the slots during READ, parks at 0 otherwise
  always_ff @(posedge clk) begin
    if (rst)                                        addr_q <= '0;
    else if (sc_q == SC_READ && addr_q != LAST_ADDR) addr_q <= addr_q + 1'b1;
    else                                            addr_q <= '0;
  end

  // mem_rdata for the address of a READ cycle is captured at that cycle's
  // closing edge, so each slot is presented for the one cycle that follows
  always_ff @(posedge clk) begin
    if (rst || sc_q != SC_READ) begin
      obstacle       <= '0;
      obstacle_valid <= 1'b0;
      firstrow       <= 1'b0;
    end else begin
      obstacle       <= mem_rdata;
      obstacle_valid <= obs_type(mem_rdata) != OBS_EMPTY;
      firstrow       <= obs_type(mem_rdata) != OBS_EMPTY && obs_depth(mem_rdata) < FR_DEPTH;
    end
  end

  // Sticky overrun flag: a frame arrived before the previous scan finished
  always_ff @(posedge clk) begin
    if (rst)                              frame_overrun <= 1'b0;
    else if (frame_start && sc_q != SC_IDLE) frame_overrun <= 1'b1;
  end

  button_latch u_latch (
    .clk   (clk),
    .rst   (rst),
    .en    (gs_q == GS_RUN),
    .clr   (restart || go_over),
    .tick  (tick),
    .pulse (btn_in),
    .fwd   (btn_fwd)
  );

  assign mem_addr     = addr_q;
  assign gl_new_frame = tick;
  assign gl_jump      = btn_fwd.jump;
  assign gl_duck      = btn_fwd.duck;
  assign gl_left      = btn_fwd.left;
  assign gl_right     = btn_fwd.right;
  assign gl_rst       = rst_pulse_q;
  assign game_state   = gs_q;
  assign scan_busy    = (sc_q != SC_IDLE);

endmodule

// File: tb/tb_frame_scheduler.sv
// Self-checking bench for frame_scheduler: slot table vectors, per-frame
// scoreboard of slot presentations, and hand sequences for game-state corners.
module tb_frame_scheduler;
  import game_pkg::*;

  logic        clk = 1'b0;
  logic        rst, frame_start, btn_jump, btn_duck, btn_left, btn_right, game_over_in;
  logic [4:0]  mem_addr;
  logic [15:0] mem_rdata, obstacle;
  logic        obstacle_valid, firstrow, gl_new_frame, gl_jump, gl_duck, gl_left, gl_right;
  logic        gl_rst, scan_busy, frame_overrun;
  logic [1:0]  game_state;

  always #5 clk = ~clk;

  frame_scheduler dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .btn_jump(btn_jump), .btn_duck(btn_duck), .btn_left(btn_left), .btn_right(btn_right),
    .game_over_in(game_over_in), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .obstacle(obstacle), .obstacle_valid(obstacle_valid), .firstrow(firstrow),
    .gl_new_frame(gl_new_frame), .gl_jump(gl_jump), .gl_duck(gl_duck),
    .gl_left(gl_left), .gl_right(gl_right), .gl_rst(gl_rst), .game_state(game_state),
    .scan_busy(scan_busy), .frame_overrun(frame_overrun)
  );

  // Asynchronous-read slot memory: data for mem_addr is ready by the next edge
  logic [15:0] mem [32];
  assign mem_rdata = mem[mem_addr];

  typedef struct {
    logic [15:0] word;
    logic        v;
    logic        f;
  } slot_exp_t;

  typedef struct {
    int          slot;
    logic [15:0] word;
    logic        v;
    logic        f;
  } vec_t;

  slot_exp_t exp_slot [32];
  slot_exp_t sb [$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) begin
      mem[i]      = 16'h0;
      exp_slot[i] = '{16'h0, 1'b0, 1'b0};
    end
  endtask

  task automatic set_slot(input int i, input logic [15:0] w, input logic v, input logic f);
    mem[i]      = w;
    exp_slot[i] = '{w, v, f};
  endtask

  // One scan: frame_start in cycle 0, buttons pulsed at the given cycle
  // offsets (-1 = none), optional second frame_start; checks every cycle 1..35
  task automatic run_frame(input int j_at, input int d_at, input int l_at, input int r_at,
                           input int fs2_at, input logic ej, input logic ed,
                           input logic el, input logic er,
                           output int nvalid, output int nfirst);
    slot_exp_t e;
    nvalid = 0;
    nfirst = 0;
    sb.delete();
    for (int s = 0; s < 32; s++) sb.push_back(exp_slot[s]);
    frame_start = 1'b1;
    btn_jump = (j_at == 0); btn_duck = (d_at == 0);
    btn_left = (l_at == 0); btn_right = (r_at == 0);
    step();
    for (int c = 1; c <= 35; c++) begin
      frame_start = (c == fs2_at);
      btn_jump = (c == j_at); btn_duck = (c == d_at);
      btn_left = (c == l_at); btn_right = (c == r_at);
      @(negedge clk);
      if (c == 1)  chk("mem_addr_first", mem_addr, 0);
      if (c == 32) chk("mem_addr_last", mem_addr, 31);
      if (c == 35) chk("mem_addr_idle", mem_addr, 0);
      chk("scan_busy", scan_busy, (c <= 34));
      if (c >= 2 && c <= 33) begin
        if (sb.size() == 0) begin
          chk("scoreboard_empty", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("obstacle", obstacle, e.word);
          chk("obstacle_valid", obstacle_valid, e.v);
          chk("firstrow", firstrow, e.f);
        end
      end else begin
        chk("valid_outside_window", obstacle_valid, 0);
      end
      if (obstacle_valid) nvalid++;
      if (firstrow) nfirst++;
      chk("gl_new_frame", gl_new_frame, (c == 34));
      if (c == 34) chk("gl_buttons_at_tick", {gl_jump, gl_duck, gl_left, gl_right}, {ej, ed, el, er});
      else         chk("gl_buttons_off_tick", {gl_jump, gl_duck, gl_left, gl_right}, 0);
      step();
    end
    frame_start = 1'b0;
    btn_jump = 1'b0; btn_duck = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vt [9];
    int nv, nf, ticks;

    rst = 1'b1; frame_start = 1'b0; game_over_in = 1'b0;
    btn_jump = 1'b0; btn_duck = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    clear_mem();
    repeat (3) step();
    @(negedge clk);
    chk("reset_outputs", {obstacle, obstacle_valid, firstrow, gl_new_frame, gl_rst,
                          scan_busy, frame_overrun}, 0);
    chk("reset_state", game_state, GS_TITLE);
    chk("reset_mem_addr", mem_addr, 0);
    rst = 1'b0;
    step();

    // TITLE: frame_start starts no scan
    frame_start = 1'b1; step(); frame_start = 1'b0;
    @(negedge clk);
    chk("title_no_scan", scan_busy, 0);
    step();

    // TITLE -> RUN via a button; frame_start on the gl_rst cycle is dropped
    btn_jump = 1'b1; step(); btn_jump = 1'b0; frame_start = 1'b1;
    @(negedge clk);
    chk("title_gl_rst", gl_rst, 1);
    chk("title_to_run", game_state, GS_RUN);
    step(); frame_start = 1'b0;
    @(negedge clk);
    chk("gl_rst_one_cycle", gl_rst, 0);
    chk("fs_on_rst_dropped", scan_busy, 0);
    step();

    // Table of slot words with hand-derived valid/firstrow
    vt[0] = '{0,  16'h2040, 1'b1, 1'b1};  // LOW depth 64
    vt[1] = '{2,  16'h8190, 1'b1, 1'b0};  // TRAIN depth 400
    vt[2] = '{4,  16'h813F, 1'b1, 1'b1};  // TRAIN depth 319
    vt[3] = '{6,  16'h0040, 1'b0, 1'b0};  // empty type, shallow depth
    vt[4] = '{9,  16'hC140, 1'b1, 1'b0};  // MOVING depth 320
    vt[5] = '{13, 16'hA000, 1'b1, 1'b1};  // RAMP depth 0
    vt[6] = '{17, 16'h07FF, 1'b0, 1'b0};  // empty type, max depth
    vt[7] = '{22, 16'hFFFF, 1'b1, 1'b0};  // unused type 7, depth 2047
    vt[8] = '{31, 16'h393F, 1'b1, 1'b1};  // LOW lane 3 depth 319, last slot
    clear_mem();
    for (int i = 0; i < 9; i++) set_slot(vt[i].slot, vt[i].word, vt[i].v, vt[i].f);
    // The restart button must not show up at the first tick
    run_frame(-1, -1, -1, -1, -1, 0, 0, 0, 0, nv, nf);
    chk("table_valid_count", nv, 7);
    chk("table_first_count", nf, 4);

    // Slots 0 and 5 LOW depth 64: two valid, two firstrow
    clear_mem();
    set_slot(0, 16'h2040, 1'b1, 1'b1);
    set_slot(5, 16'h2040, 1'b1, 1'b1);
    run_frame(-1, -1, -1, -1, -1, 0, 0, 0, 0, nv, nf);
    chk("t1_valid_count", nv, 2);
    chk("t1_first_count", nf, 2);

    // Jump mid-frame, left on the tick cycle carries into the next frame
    run_frame(12, -1, 34, -1, -1, 1, 0, 0, 0, nv, nf);
    run_frame(-1, -1, -1, -1, -1, 0, 0, 1, 0, nv, nf);
    // Left and right in one frame cancel, and nothing leaks into the next
    run_frame(-1, -1, 5, 20, -1, 0, 0, 0, 0, nv, nf);
    run_frame(-1, -1, -1, -1, -1, 0, 0, 0, 0, nv, nf);
    // Jump and duck both forwarded
    run_frame(3, 8, -1, -1, -1, 1, 1, 0, 0, nv, nf);

    // frame_start 10 cycles into a scan: ignored, overrun sticky
    chk("overrun_clear", frame_overrun, 0);
    run_frame(-1, -1, -1, -1, 10, 0, 0, 0, 0, nv, nf);
    repeat (5) step();
    @(negedge clk);
    chk("no_second_scan", scan_busy, 0);
    chk("overrun_set", frame_overrun, 1);
    step();

    // Game over, holdoff of 60 frames
    game_over_in = 1'b1; step(); game_over_in = 1'b0;
    @(negedge clk);
    chk("run_to_over", game_state, GS_OVER);
    step();
    for (int i = 0; i < 59; i++) begin
      frame_start = 1'b1; step(); frame_start = 1'b0;
      if (i == 0) begin
        @(negedge clk);
        chk("over_no_scan", scan_busy, 0);
      end
      step();
    end
    btn_left = 1'b1; step(); btn_left = 1'b0;
    @(negedge clk);
    chk("holdoff_59_no_rst", gl_rst, 0);
    chk("holdoff_59_state", game_state, GS_OVER);
    step();
    frame_start = 1'b1; step(); frame_start = 1'b0; step();
    btn_right = 1'b1; step(); btn_right = 1'b0;
    @(negedge clk);
    chk("holdoff_60_rst", gl_rst, 1);
    chk("holdoff_60_run", game_state, GS_RUN);
    step();
    @(negedge clk);
    chk("restart_rst_one_cycle", gl_rst, 0);
    step();
    // Buttons pressed in OVER were not latched
    run_frame(-1, -1, -1, -1, -1, 0, 0, 0, 0, nv, nf);
    chk("overrun_still_set", frame_overrun, 1);

    // rst mid-scan aborts everything, no tick afterwards
    frame_start = 1'b1; step(); frame_start = 1'b0;
    repeat (14) step();
    @(negedge clk);
    chk("mid_scan_busy", scan_busy, 1);
    rst = 1'b1; step(); rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_outputs", {obstacle, obstacle_valid, firstrow, gl_new_frame, gl_jump,
                            gl_duck, gl_left, gl_right, gl_rst, scan_busy, frame_overrun}, 0);
    chk("rst_mid_state", game_state, GS_TITLE);
    chk("rst_mid_addr", mem_addr, 0);
    ticks = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      @(negedge clk);
      if (gl_new_frame) ticks++;
    end
    chk("no_tick_after_rst", ticks, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
